rom_lookup_ctrl: RTL and testbench

//  Upstream driver for the 2N-bit ROM lookup table: accepts operand pairs (a,b) on a valid/ready

---
 rtl/rom_lookup_pkg.sv | 19 +
 rtl/rom_lookup_fifo.sv | 72 +++++++
 rtl/rom_lookup_ctrl.sv | 92 +++++++++
 tb/tb_rom_lookup_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_lookup_pkg.sv
// Shared widths and helpers for the ROM lookup controller and its result FIFO.
// Defaults describe the N=4, OUT_DEPTH=4 build.
package rom_lookup_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int N_DEF     = 4;
  localparam int DEPTH_DEF = 4;
  localparam int ADDR_W    = 2 * N_DEF;
  localparam int DATA_W    = ADDR_W;
  localparam int PTR_W     = clog2(DEPTH_DEF);
  localparam int CNT_W     = 16;

endpackage

// File: rtl/rom_lookup_fifo.sv
// Synchronous result FIFO: push/pop in one cycle, head visible combinationally.
// When empty the head output holds the most recently popped word.
module rom_lookup_fifo
  import rom_lookup_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        push_dat_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        head_dat_o,
  output logic                    head_vld_o,
  output logic [clog2(DEPTH):0]   count_o
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             not_empty;
  logic             do_pop;

  assign not_empty = (count_q != '0);
  // A pop against an empty FIFO is ignored rather than underflowing.
  assign do_pop    = pop_i && not_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign head_vld_o = not_empty;
  assign head_dat_o = not_empty ? mem_q[rd_ptr_q] : last_q;
  assign count_o    = count_q;

endmodule

// File: rtl/rom_lookup_ctrl.sv
// ROM lookup driver: accept {a,b}, drive the ROM for one cycle, queue the word; 2-cycle latency.
// Credit-based in_ready never overflows the FIFO. LOOKUP_CNT_EN adds a saturating pop counter.
module rom_lookup_ctrl
  import rom_lookup_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int OUT_DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [2*N-1:0]   rom_address,
  output logic             rom_en,
  output logic             rom_read_en,
  input  logic [2*N-1:0]   rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_data
`ifdef LOOKUP_CNT_EN
  ,
  output logic [CNT_W-1:0] lookup_count
`endif
);

  localparam int AW = 2 * N;
  localparam int PW = clog2(OUT_DEPTH);

  logic [AW-1:0] addr_q, addr_d;
  logic          stage_vld_q, stage_vld_d;
  logic [PW:0]   fifo_count;
  logic          accept;
  logic          pop;

  // Credits count everything accepted but not yet popped; a same-cycle pop is not credited.
  assign in_ready = ({1'b0, fifo_count} + {{PW{1'b0}}, stage_vld_q}) < (PW + 2)'(OUT_DEPTH);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    addr_d      = addr_q;
    stage_vld_d = accept;
    if (accept) addr_d = {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      stage_vld_q <= stage_vld_d;
    end
  end

  assign rom_address = addr_q;
  assign rom_en      = stage_vld_q;
  assign rom_read_en = stage_vld_q;

  rom_lookup_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (stage_vld_q),
    .push_dat_i (rom_data),
    .pop_i      (pop),
    .head_dat_o (out_data),
    .head_vld_o (out_valid),
    .count_o    (fifo_count)
  );

`ifdef LOOKUP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign lookup_count = cnt_q;
`endif

endmodule

// File: tb/tb_rom_lookup_ctrl.sv
// Bench for rom_lookup_ctrl: ROM returns a*b; a queue-based reference model tracks outstanding results.
module tb_rom_lookup_ctrl;
  import rom_lookup_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [7:0] rom_address;
  logic       rom_en, rom_read_en;
  logic [7:0] rom_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef LOOKUP_CNT_EN
  logic [15:0] lookup_count;
`endif

  rom_lookup_ctrl #(.N(4), .OUT_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .rom_address (rom_address),
    .rom_en      (rom_en),
    .rom_read_en (rom_read_en),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef LOOKUP_CNT_EN
    ,
    .lookup_count(lookup_count)
`endif
  );

  always #5 clk = ~clk;

  assign rom_data = {4'b0, rom_address[7:4]} * {4'b0, rom_address[3:0]};

  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t       q[$];
  int         total = 0;
  int         bad   = 0;
  int         cycle = 0;
  logic [7:0] exp_addr;
  logic [7:0] last_pop;
  logic       acc_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_addr = 8'h00;
    last_pop = 8'h00;
  endtask

  // One clock of stimulus with model checks before and after the active edge.
  task automatic cyc(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ordy);
    logic exp_ov;
    logic pop;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    exp_ov = (q.size() > 0) && (cycle >= q[0].t + 2);
    chk("in_ready", in_ready, q.size() < 4);
    chk("out_valid", out_valid, exp_ov);
    chk("out_data", out_data, exp_ov ? q[0].d : last_pop);
    acc_g = v && in_ready;
    pop   = exp_ov && ordy;
    if (pop) begin
      last_pop = q[0].d;
      void'(q.pop_front());
    end
    if (acc_g) begin
      q.push_back('{d: {4'b0, a} * {4'b0, b}, t: cycle});
      exp_addr = {a, b};
    end
    @(posedge clk);
    #1;
    cycle++;
    chk("rom_en", rom_en, acc_g);
    chk("rom_read_en", rom_read_en, acc_g);
    chk("rom_address", rom_address, exp_addr);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() > 0; k++) cyc(1'b0, 4'h0, 4'h0, 1'b1);
    chk("drain_left", q.size(), 0);
  endtask

  task automatic check_reset_state();
    chk("rst_rom_address", rom_address, 8'h00);
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_rom_read_en", rom_read_en, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int n;
    int idx;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    // Single lookup 3*5 with the 2-cycle latency
    cyc(1'b1, 4'd3, 4'd5, 1'b0);
    chk("t1_addr", rom_address, 8'h35);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0);
    chk("t1_out_data", out_data, 8'h0F);
    drain();

    // Back-to-back streaming of (i,i)
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 4'(i), 4'(i), 1'b1);
      chk("t2_accept", acc_g, 1'b1);
    end
    drain();

    // Stall output while offering 6 pairs, then release
    idx = 0;
    for (int k = 0; k < 40 && idx < 6; k++) begin
      cyc(1'b1, 4'(idx + 2), 4'(idx + 9), k >= 8);
      if (acc_g) idx++;
    end
    chk("t3_accepted", idx, 6);
    drain();

    // Random valid/ready stalls
    n = 0;
    for (int k = 0; k < 20000 && n < 1000; k++) begin
      cyc(($urandom % 4) != 0, 4'($urandom), 4'($urandom), ($urandom % 3) != 0);
      if (acc_g) n++;
    end
    chk("t4_accepted", n, 1000);
    drain();

    // Asynchronous reset with 3 buffered and 1 in the stage
    for (int k = 0; k < 4; k++) cyc(1'b1, 4'(k + 1), 4'(k + 4), 1'b0);
    chk("t5_outstanding", q.size(), 4);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'd2, 4'd7, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b1);
    chk("t5_out_data", last_pop, 8'h0E);
    drain();

`ifdef LOOKUP_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("cnt_reset", lookup_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc(1'b1, 4'(k), 4'(k + 1), 1'b1);
    drain();
    chk("cnt_five", lookup_count, 16'd5);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    #1;
    release dut.cnt_q;
    for (int k = 0; k < 3; k++) cyc(1'b1, 4'(k), 4'(k), 1'b1);
    drain();
    chk("cnt_sat", lookup_count, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
